frac_clock_divider: RTL and testbench

FRAC_CLOCK_DIVIDER -- requirements
Module: frac_clock_divider

---
 rtl/frac_clock_divider.sv | 95 +++++++++
 tb/tb_frac_clock_divider.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/frac_clock_divider.sv
// Fractional clock-enable divider: emits a one-cycle tick every div_int.div_frac enabled cycles.
// Optional fractional accumulator compiled in only when CLKDIV_FRAC_EN is defined.
module frac_clock_divider #(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              restart,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              tick
);

  localparam logic [INT_W-1:0] CNT_ONE = {{(INT_W-1){1'b0}}, 1'b1};
  localparam logic [INT_W:0]   LIM_ONE = {{INT_W{1'b0}}, 1'b1};

  logic [INT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             extra;
  logic [INT_W:0]   d_eff;
  logic [INT_W:0]   limit;
  logic             period_end;

  // Zero divisor selects the full 2^INT_W range; one extra bit keeps the limit from overflowing.
  assign d_eff      = (div_int == '0) ? {1'b1, {INT_W{1'b0}}} : {1'b0, div_int};
  assign limit      = d_eff - LIM_ONE + {{INT_W{1'b0}}, extra};
  assign period_end = ({1'b0, cnt_q} >= limit);

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (restart) begin
      cnt_d = '0;
    end else if (enable) begin
      if (period_end) begin
        tick_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

`ifdef CLKDIV_FRAC_EN
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              extra_q, extra_d;
  logic [FRAC_W:0]   acc_sum;

  // Carry out of the fraction lengthens the following period by one cycle.
  assign acc_sum = {1'b0, acc_q} + {1'b0, div_frac};

  always_comb begin
    acc_d   = acc_q;
    extra_d = extra_q;
    if (restart) begin
      acc_d   = '0;
      extra_d = 1'b0;
    end else if (enable && period_end) begin
      acc_d   = acc_sum[FRAC_W-1:0];
      extra_d = acc_sum[FRAC_W];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q   <= '0;
      extra_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      extra_q <= extra_d;
    end
  end

  assign extra = extra_q;
`else
  logic unused_div_frac;
  assign unused_div_frac = ^div_frac;
  assign extra           = 1'b0;
`endif

endmodule

// File: tb/tb_frac_clock_divider.sv
// Directed bench for frac_clock_divider: vector table plus multi-cycle period sequences.
module tb_frac_clock_divider;

  logic        clock = 1'b0;
  logic        reset, enable, restart;
  logic [15:0] div_int;
  logic [7:0]  div_frac;
  logic        tick;

  logic        b_reset, b_enable, b_restart;
  logic [3:0]  b_div_int;
  logic [7:0]  b_div_frac;
  logic        b_tick;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  frac_clock_divider #(.INT_W(16), .FRAC_W(8)) dut (
    .clock(clock), .reset(reset), .enable(enable), .restart(restart),
    .div_int(div_int), .div_frac(div_frac), .tick(tick)
  );

  frac_clock_divider #(.INT_W(4), .FRAC_W(8)) dut_short (
    .clock(clock), .reset(b_reset), .enable(b_enable), .restart(b_restart),
    .div_int(b_div_int), .div_frac(b_div_frac), .tick(b_tick)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic        rs;
    logic [15:0] di;
    logic [7:0]  df;
    logic        exp_tick;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic rst, input logic en, input logic rs,
                     input logic [15:0] di, input logic [7:0] df, input logic exp_tick);
    vec_t v;
    v.rst = rst; v.en = en; v.rs = rs; v.di = di; v.df = df; v.exp_tick = exp_tick;
    vecs.push_back(v);
  endtask

  // Counts enabled edges up to and including the next tick; 1000 marks a timeout.
  task automatic measure(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!tick && n < 1000);
  endtask

  task automatic do_reset(input logic [15:0] di, input logic [7:0] df);
    reset = 1'b1; enable = 1'b1; restart = 1'b0; div_int = di; div_frac = df;
    step();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int total;
    int exp_len[6];

    reset = 1'b1; enable = 1'b0; restart = 1'b0; div_int = 16'd3; div_frac = 8'd0;
    b_reset = 1'b1; b_enable = 1'b1; b_restart = 1'b0; b_div_int = 4'd0; b_div_frac = 8'd0;

    // rst en rs div_int div_frac expected tick
    add(1, 1, 0, 3, 0, 0);
    add(0, 1, 0, 3, 0, 0); add(0, 1, 0, 3, 0, 0); add(0, 1, 0, 3, 0, 1);
    add(0, 1, 0, 3, 0, 0); add(0, 1, 0, 3, 0, 0); add(0, 1, 0, 3, 0, 1);
    add(0, 1, 0, 3, 0, 0); add(0, 1, 0, 3, 0, 0); add(0, 1, 0, 3, 0, 1);
    add(0, 0, 0, 3, 0, 0); add(0, 0, 0, 3, 0, 0);
    add(0, 1, 0, 3, 0, 0); add(0, 1, 0, 3, 0, 0); add(0, 1, 0, 3, 0, 1);
    add(0, 1, 0, 3, 0, 0); add(0, 1, 0, 3, 0, 0);
    add(1, 1, 1, 3, 0, 0);
    add(0, 1, 0, 3, 0, 0); add(0, 1, 0, 3, 0, 0); add(0, 1, 0, 3, 0, 1);
    add(0, 1, 0, 1, 0, 1); add(0, 1, 0, 1, 0, 1); add(0, 1, 0, 1, 0, 1);
    add(0, 1, 1, 1, 0, 0); add(0, 1, 0, 1, 0, 1); add(0, 1, 0, 1, 0, 1);
    add(0, 1, 0, 3, 0, 0);
    add(0, 0, 1, 3, 0, 0);
    add(0, 1, 0, 3, 0, 0); add(0, 1, 0, 3, 0, 0); add(0, 1, 0, 3, 0, 1);

    foreach (vecs[i]) begin
      reset = vecs[i].rst; enable = vecs[i].en; restart = vecs[i].rs;
      div_int = vecs[i].di; div_frac = vecs[i].df;
      step();
      check($sformatf("vec%0d_tick", i), {31'd0, tick}, {31'd0, vecs[i].exp_tick});
    end

    // div_int=0 on a 4-bit build means divide by 16.
    check("short_reset_tick", {31'd0, b_tick}, 32'd0);
    b_reset = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      step();
      check($sformatf("short_div16_edge%0d", k), {31'd0, b_tick}, (k % 16 == 0) ? 32'd1 : 32'd0);
    end

    // Enable dropped mid-period at cnt=4.
    do_reset(16'd10, 8'd0);
    for (int k = 0; k < 4; k++) step();
    enable = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("en_low_tick%0d", k), {31'd0, tick}, 32'd0);
    end
    enable = 1'b1;
    measure(n);
    check("en_resume_period", n, 6);

    // Lowering div_int below cnt ends the period on the next edge.
    do_reset(16'd100, 8'd0);
    for (int k = 0; k < 50; k++) step();
    check("pre_change_tick", {31'd0, tick}, 32'd0);
    div_int = 16'd20;
    step();
    check("div_drop_tick", {31'd0, tick}, 32'd1);
    for (int k = 0; k < 7; k++) step();
    restart = 1'b1;
    step();
    check("restart_tick", {31'd0, tick}, 32'd0);
    restart = 1'b0;
    measure(n);
    check("restart_full_period", n, 20);

    // Reset mid-period discards the partial period.
    do_reset(16'd5, 8'd0);
    step(); step();
    reset = 1'b1;
    step();
    check("mid_reset_tick", {31'd0, tick}, 32'd0);
    reset = 1'b0;
    measure(n);
    check("post_reset_period", n, 5);

    // Divide by 2.5 (or exactly 2 when the fractional path is not built).
`ifdef CLKDIV_FRAC_EN
    exp_len = '{2, 2, 3, 2, 3, 2};
`else
    exp_len = '{2, 2, 2, 2, 2, 2};
`endif
    do_reset(16'd2, 8'h80);
    total = 0;
    for (int p = 0; p < 100; p++) begin
      measure(n);
      total += n;
      if (p < 5) check($sformatf("half_period%0d", p), n, exp_len[p]);
    end
`ifdef CLKDIV_FRAC_EN
    check("half_100_ticks_cycles", total, 249);
`else
    check("half_100_ticks_cycles", total, 200);
`endif

    // div_frac=0xFF: near 3 with the fraction, strictly 2 without.
`ifdef CLKDIV_FRAC_EN
    exp_len = '{2, 2, 3, 3, 3, 3};
`else
    exp_len = '{2, 2, 2, 2, 2, 2};
`endif
    do_reset(16'd2, 8'hFF);
    for (int p = 0; p < 6; p++) begin
      measure(n);
      check($sformatf("ff_period%0d", p), n, exp_len[p]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
